instruction_cache: RTL and testbench

Direct-mapped, read-only instruction cache between the program counter and instruction memory. It turns the PC byte address into a 32-bit instruction in the same cycle on a hit. On a miss it raises `busywait` to stall the PC, fetches a 16-byte block from instruction memory, and then serves the instruction. It owns the fetch-side stall for the single-cycle CPU.

---
 rtl/instruction_cache.sv | 153 +++++++++++++++
 tb/tb_instruction_cache.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_cache.sv
// instruction_cache
//   Direct-mapped, read-only instruction cache between the PC and instruction
//   memory. A hit returns the addressed word combinationally in the same
//   cycle. A miss raises busywait, fetches the whole 16-byte block for the
//   latched {tag,index}, installs it, and then serves the word from the
//   following IDLE cycle.
//
//   Optional feature: define INSTR_CACHE_STATS_EN to add saturating 16-bit
//   hit/miss counters. Without it those ports do not exist.
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   synchronous, active-low reset
//   pc            in   32-bit byte address; bits [1:0] and bits above the tag ignored
//   instruction   out  32-bit word, valid while busywait is low
//   busywait      out  stall request to the PC
//   mem_read      out  block read request to instruction memory
//   mem_address   out  block address {tag,index}
//   mem_readdata  in   128-bit block, word 0 in [31:0]
//   mem_busywait  in   memory not ready; data valid when low during mem_read
//   hit_count     out  (INSTR_CACHE_STATS_EN) IDLE cycles that hit
//   miss_count    out  (INSTR_CACHE_STATS_EN) IDLE->MEM_READ transitions
//
// State | meaning
//   IDLE     | serve hits; on a miss latch {tag,index} and start a refill
//   MEM_READ | hold mem_read high until memory drops mem_busywait, then install

module instruction_cache #(
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS   = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [31:0]                    pc,
  output logic [31:0]                    instruction,
  output logic                           busywait,
  output logic                           mem_read,
  output logic [TAG_BITS+INDEX_BITS-1:0] mem_address,
  input  logic [127:0]                   mem_readdata,
  input  logic                           mem_busywait
`ifdef INSTR_CACHE_STATS_EN
  ,
  output logic [15:0]                    hit_count,
  output logic [15:0]                    miss_count
`endif
);

  localparam int LINES   = 1 << INDEX_BITS;
  localparam int BLK_MSB = 4 + INDEX_BITS + TAG_BITS - 1;

  typedef enum logic {IDLE, MEM_READ} state_t;

  state_t                 state;
  logic [LINES-1:0]       valid;
  logic [TAG_BITS-1:0]    tags [LINES];
  logic [127:0]           data [LINES];

  logic [1:0]             offset;
  logic [INDEX_BITS-1:0]  index;
  logic [TAG_BITS-1:0]    tag;
  logic                   hit;
  logic [127:0]           line;
  logic [31:0]            word;
  logic                   refill;

  // mem_address doubles as the miss register: it is loaded on the miss
  // and held for the whole refill, so pc changes cannot redirect the fetch.
  logic [INDEX_BITS-1:0]  miss_index;
  logic [TAG_BITS-1:0]    miss_tag;

  logic                   unused_pc;

  assign offset     = pc[3:2];
  assign index      = pc[4+INDEX_BITS-1:4];
  assign tag        = pc[BLK_MSB:4+INDEX_BITS];
  assign unused_pc  = ^{pc[1:0], pc[31:BLK_MSB+1]};

  assign miss_index = mem_address[INDEX_BITS-1:0];
  assign miss_tag   = mem_address[TAG_BITS+INDEX_BITS-1:INDEX_BITS];

  assign hit    = valid[index] && (tags[index] == tag);
  assign line   = data[index];
  assign refill = reset && (state == MEM_READ) && !mem_busywait;

  always_comb begin
    word = 32'h0;
    case (offset)
      2'd0: word = line[31:0];
      2'd1: word = line[63:32];
      2'd2: word = line[95:64];
      2'd3: word = line[127:96];
      default: word = 32'h0;
    endcase
  end

  // Both outputs are held at zero during reset so the PC sees a clean start.
  always_comb begin
    busywait    = 1'b0;
    instruction = 32'h0;
    if (reset) begin
      instruction = word;
      busywait    = (state == MEM_READ) || !hit;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      valid       <= '0;
      mem_read    <= 1'b0;
      mem_address <= '0;
`ifdef INSTR_CACHE_STATS_EN
      hit_count   <= 16'h0;
      miss_count  <= 16'h0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!hit) begin
            mem_address <= {tag, index};
            mem_read    <= 1'b1;
            state       <= MEM_READ;
`ifdef INSTR_CACHE_STATS_EN
            if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
`endif
          end
`ifdef INSTR_CACHE_STATS_EN
          else if (hit_count != 16'hFFFF) begin
            hit_count <= hit_count + 16'd1;
          end
`endif
        end
        MEM_READ: begin
          if (!mem_busywait) begin
            valid[miss_index] <= 1'b1;
            mem_read          <= 1'b0;
            state             <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line storage needs no reset: the valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (refill) begin
      data[miss_index] <= mem_readdata;
      tags[miss_index] <= miss_tag;
    end
  end

endmodule

// File: tb/tb_instruction_cache.sv
module tb_instruction_cache;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [31:0]  pc = 32'h0;
  logic [31:0]  instruction;
  logic         busywait;
  logic         mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;
`ifdef INSTR_CACHE_STATS_EN
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int lat_cfg  = 3;
  int cnt      = 0;

  // reference cache contents: which tag each line holds, if any
  bit         mvalid [8];
  logic [2:0] mtag   [8];

  always #5 clk = ~clk;

  instruction_cache dut (
    .clk          (clk),
    .reset        (reset),
    .pc           (pc),
    .instruction  (instruction),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
`ifdef INSTR_CACHE_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  function automatic logic [31:0] word_of(input logic [5:0] blk, input logic [1:0] w);
    return {16'hC0DE, 2'b00, blk, 6'b000000, w};
  endfunction

  // memory: data is a fixed function of the block address, ready after lat_cfg cycles
  assign mem_readdata = {word_of(mem_address, 2'd3), word_of(mem_address, 2'd2),
                         word_of(mem_address, 2'd1), word_of(mem_address, 2'd0)};
  assign mem_busywait = !(mem_read && (cnt == lat_cfg - 1));

  always @(posedge clk) begin
    if (mem_read && mem_busywait) cnt <= cnt + 1;
    else cnt <= 0;
  end

  function automatic logic [5:0] blk_of(input logic [31:0] a);
    return a[9:4];
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return mvalid[a[6:4]] && (mtag[a[6:4]] == a[9:7]);
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return word_of(blk_of(a), a[3:2]);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) mvalid[i] = 1'b0;
  endtask

  task automatic model_fill(input logic [31:0] a);
    mvalid[a[6:4]] = 1'b1;
    mtag[a[6:4]]   = a[9:7];
  endtask

  task automatic check(input string tagn, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tagn, obs, exp);
    end
  endtask

  // Called mid-low-phase; presents a, checks hit/miss, follows any refill,
  // checks the served word, and returns mid-low-phase of the next cycle.
  task automatic fetch(input logic [31:0] a, input int lat);
    bit exp_hit;
    int n;
    lat_cfg = lat;
    pc = a;
    exp_hit = model_hit(a);
    #1;
    check("hit_busywait", {31'b0, busywait}, {31'b0, !exp_hit});
    if (!exp_hit) begin
      n = 0;
      while (busywait === 1'b1 && n < 64) begin
        if (n == 0) check("miss_idle_mem_read", {31'b0, mem_read}, 32'h0);
        else begin
          check("refill_mem_read", {31'b0, mem_read}, 32'h1);
          check("refill_mem_address", {26'b0, mem_address}, {26'b0, blk_of(a)});
        end
        @(negedge clk); #1;
        n++;
      end
      check("stall_cycles", n, lat + 1);
      model_fill(a);
    end
    check("instruction", instruction, exp_word(a));
    @(negedge clk); #1;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b0;
    repeat (cycles) @(negedge clk);
    #1;
    check("reset_busywait", {31'b0, busywait}, 32'h0);
    check("reset_instruction", instruction, 32'h0);
    check("reset_mem_read", {31'b0, mem_read}, 32'h0);
    check("reset_mem_address", {26'b0, mem_address}, 32'h0);
    reset = 1'b1;
    model_clear();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    model_clear();
    @(negedge clk); #1;

    // cold start
    pc = 32'h0;
    do_reset(2);
    fetch(32'h000, 3);
    // same-line hits
    fetch(32'h004, 3);
    fetch(32'h008, 3);
    fetch(32'h00C, 3);

    // conflict on index 0
    fetch(32'h080, 2);
    fetch(32'h000, 1);
    fetch(32'h084, 4);
    // upper pc bits ignored: 0x484 aliases 0x084
    fetch(32'h484, 1);

    // reset one cycle before mem_busywait would fall
    lat_cfg = 3;
    pc = 32'h030; #1;
    check("rst_mid_miss", {31'b0, busywait}, 32'h1);
    @(negedge clk); #1;
    check("rst_mid_mem_read", {31'b0, mem_read}, 32'h1);
    @(negedge clk); #1;
    reset = 1'b0;
    @(negedge clk); #1;
    check("rst_mid_drop_mem_read", {31'b0, mem_read}, 32'h0);
    check("rst_mid_busywait", {31'b0, busywait}, 32'h0);
    check("rst_mid_instruction", instruction, 32'h0);
    reset = 1'b1;
    model_clear();
    fetch(32'h030, 3);

    // pc moves during MEM_READ: refill keeps the latched block
    lat_cfg = 3;
    pc = 32'h010; #1;
    check("redirect_miss", {31'b0, busywait}, 32'h1);
    @(negedge clk); #1;
    pc = 32'h020; #1;
    for (int i = 0; i < 3; i++) begin
      check("redirect_mem_address", {26'b0, mem_address}, 32'h01);
      check("redirect_busywait", {31'b0, busywait}, 32'h1);
      @(negedge clk); #1;
    end
    model_fill(32'h010);
    check("redirect_idle_miss", {31'b0, busywait}, 32'h1);
    check("redirect_idle_mem_read", {31'b0, mem_read}, 32'h0);
    @(negedge clk); #1;
    check("redirect_second_address", {26'b0, mem_address}, 32'h02);
    check("redirect_second_mem_read", {31'b0, mem_read}, 32'h1);
    @(negedge clk); #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("redirect_served", {31'b0, busywait}, 32'h0);
    check("redirect_instruction", instruction, exp_word(32'h020));
    model_fill(32'h020);
    @(negedge clk); #1;
    fetch(32'h014, 1);

    // randomized fetch stream against the reference model
    for (int k = 0; k < 60; k++) begin
      a = ({31'b0, 1'($urandom_range(0, 1))} << 12) |
          (32'($urandom_range(0, 2)) << 7) |
          (32'($urandom_range(0, 7)) << 4) |
          (32'($urandom_range(0, 3)) << 2) |
          32'($urandom_range(0, 3));
      fetch(a, $urandom_range(1, 4));
    end

`ifdef INSTR_CACHE_STATS_EN
    do_reset(2);
    check("stats_reset_hits", {16'b0, hit_count}, 32'd0);
    check("stats_reset_misses", {16'b0, miss_count}, 32'd0);
    fetch(32'h000, 2);
    fetch(32'h004, 2);
    fetch(32'h008, 2);
    fetch(32'h00C, 2);
    check("stats_hits", {16'b0, hit_count}, 32'd4);
    check("stats_misses", {16'b0, miss_count}, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
